pipe_hazard_unit: RTL

//  Parametrised hazard/forwarding controller for the pipelined LEGv8 core; sits beside the ID stage.

---
 rtl/pipe_hazard_pkg.sv | 19 +
 rtl/pipe_hazard_unit_fwd_select.sv | 37 +++
 rtl/pipe_hazard_unit.sv | 107 ++++++++++
 3 files changed

// File: rtl/pipe_hazard_pkg.sv
// Shared types and helpers for the LEGv8 hazard/forwarding controller.
package pipe_hazard_pkg;

  // Widest register address a scoreboard entry can hold; narrower REG_AW is zero-extended.
  localparam int SB_AW       = 8;
  localparam int FWD_REGFILE = 0;

  typedef struct packed {
    logic             valid;
    logic [SB_AW-1:0] rd;
    logic             regwrite;
    logic             is_load;
  } sb_entry_t;

  function automatic int fwd_w(input int num_stages);
    return (num_stages > 2) ? $clog2(num_stages) : 1;
  endfunction

endpackage

// File: rtl/pipe_hazard_unit_fwd_select.sv
// Youngest-match priority encoder for one EX operand; also flags a load in entry 0 feeding it.
module fwd_select
  import pipe_hazard_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int REG_AW     = 5,
  parameter int ZERO_REG   = 31,
  parameter int FWD_W      = fwd_w(NUM_STAGES)
) (
  input  sb_entry_t [NUM_STAGES-1:0] i_entries,
  input  logic      [REG_AW-1:0]     i_src,
  input  logic                       i_used,
  output logic      [FWD_W-1:0]      o_sel,
  output logic                       o_load_hit
);

  logic [NUM_STAGES-1:0] w_match;
  logic                  w_unused;

  always_comb begin
    for (int j = 0; j < NUM_STAGES; j++)
      w_match[j] = i_entries[j].valid & i_entries[j].regwrite & i_used &
                   (i_entries[j].rd == SB_AW'(i_src)) &
                   (i_src != REG_AW'(ZERO_REG));
  end

  // The oldest entry writes the regfile before ID reads it, so it is never a source.
  always_comb begin
    o_sel = FWD_W'(FWD_REGFILE);
    for (int j = NUM_STAGES-2; j >= 0; j--)
      if (w_match[j]) o_sel = FWD_W'(j+1);
  end

  assign o_load_hit = w_match[0] & i_entries[0].is_load;
  assign w_unused   = ^{i_entries, w_match[NUM_STAGES-1]};

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard/forwarding controller beside the ID stage: registered forward selects, load-use stall, branch flush.
// Optional perf counters enabled by defining HAZ_PERF_CNT_EN.
module pipe_hazard_unit
  import pipe_hazard_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int REG_AW     = 5,
  parameter int ZERO_REG   = 31,
  parameter int BR_STAGE   = 1,
  localparam int FWD_W     = fwd_w(NUM_STAGES)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rn,
  input  logic [REG_AW-1:0] id_rm,
  input  logic              id_rn_used,
  input  logic              id_rm_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_is_load,
  input  logic              br_taken,
  output logic              stall_if,
  output logic              bubble_ex,
  output logic              flush,
  output logic [FWD_W-1:0]  fwd_a,
  output logic [FWD_W-1:0]  fwd_b,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       flush_cycles
);

  sb_entry_t [NUM_STAGES-1:0] r_sb;
  sb_entry_t                  w_id_entry;
  logic [FWD_W-1:0]           w_sel_a, w_sel_b, r_fwd_a, r_fwd_b;
  logic                       w_ld_a, w_ld_b, w_load_use;

  fwd_select #(.NUM_STAGES(NUM_STAGES), .REG_AW(REG_AW), .ZERO_REG(ZERO_REG), .FWD_W(FWD_W)) u_fwd_a (
    .i_entries(r_sb), .i_src(id_rn), .i_used(id_valid & id_rn_used),
    .o_sel(w_sel_a), .o_load_hit(w_ld_a)
  );

  fwd_select #(.NUM_STAGES(NUM_STAGES), .REG_AW(REG_AW), .ZERO_REG(ZERO_REG), .FWD_W(FWD_W)) u_fwd_b (
    .i_entries(r_sb), .i_src(id_rm), .i_used(id_valid & id_rm_used),
    .o_sel(w_sel_b), .o_load_hit(w_ld_b)
  );

  assign w_load_use = w_ld_a | w_ld_b;
  assign flush      = br_taken;
  assign stall_if   = w_load_use & ~br_taken;
  assign bubble_ex  = stall_if;
  assign fwd_a      = r_fwd_a;
  assign fwd_b      = r_fwd_b;

  always_comb begin
    w_id_entry          = '0;
    w_id_entry.valid    = 1'b1;
    w_id_entry.rd       = SB_AW'(id_rd);
    w_id_entry.regwrite = id_regwrite;
    w_id_entry.is_load  = id_is_load;
  end

  // On a taken branch the instructions younger than it (entries 0..BR_STAGE-1) are wrong-path
  // and must not advance, so their shifted copies are cleared along with the dropped ID slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sb <= '0;
    end else begin
      r_sb[0] <= (id_valid & ~stall_if & ~flush) ? w_id_entry : '0;
      for (int k = 1; k < NUM_STAGES; k++)
        r_sb[k] <= (flush && k <= BR_STAGE) ? '0 : r_sb[k-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fwd_a <= '0;
      r_fwd_b <= '0;
    end else if (stall_if | flush) begin
      r_fwd_a <= FWD_W'(FWD_REGFILE);
      r_fwd_b <= FWD_W'(FWD_REGFILE);
    end else begin
      r_fwd_a <= w_sel_a;
      r_fwd_b <= w_sel_b;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] r_stall_cnt, r_flush_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (stall_if && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (flush    && r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cnt;
  assign flush_cycles = r_flush_cnt;
`else
  assign stall_cycles = '0;
  assign flush_cycles = '0;
`endif

endmodule
